// File: rtl/if_prefetch_unit_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package if_prefetch_unit_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] NOP_INST         = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_pair_t;

  function automatic logic [31:0] word_align(
    input logic [31:0] a
  );
    return a & ~32'd3;
  endfunction

endpackage

// File: rtl/if_prefetch_unit_queue.sv
// Generic synchronous FIFO with flush; flush wins over push.
module if_queue #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_rd;
  logic [AW-1:0]    r_wr;
  logic [CW-1:0]    r_cnt;
  logic             w_pop;

  assign empty = (r_cnt == '0);
  assign full  = (r_cnt == CW'(DEPTH));
  assign count = r_cnt;
  assign rdata = r_mem[r_rd];
  assign w_pop = pop & ~empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd  <= '0;
      r_wr  <= '0;
      r_cnt <= '0;
      for (int i = 0; i < DEPTH; i++)
        r_mem[i] <= '0;
    end else if (flush) begin
      r_rd  <= '0;
      r_wr  <= '0;
      r_cnt <= '0;
    end else begin
      if (push) begin
        r_mem[r_wr] <= wdata;
        r_wr        <= r_wr + AW'(1);
      end
      if (w_pop)
        r_rd <= r_rd + AW'(1);
      r_cnt <= r_cnt + CW'(push) - CW'(w_pop);
    end
  end

endmodule

// File: rtl/if_prefetch_unit.sv
// Fetch front end: owns the PC, issues IROM reads, buffers {pc, inst}.
module if_prefetch_unit
  import if_prefetch_unit_pkg::*;
#(
  parameter int          ADDR_W   = 14,
  parameter int          DEPTH    = 4,
  parameter int          ROM_SYNC = 0,
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  localparam int         CW       = $clog2(DEPTH) + 1
) (
  input  logic              cpu_clk,
  input  logic              cpu_rst,
  input  logic              fetch_en,
  output logic [ADDR_W-1:0] inst_addr,
  input  logic [31:0]       inst,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  output logic              id_valid,
  input  logic              id_ready,
  output logic [31:0]       id_pc,
  output logic [31:0]       id_pc4,
  output logic [31:0]       id_inst,
  output logic [CW-1:0]     q_count
);

  localparam bit SYNC = (ROM_SYNC != 0);

  logic [31:0] r_fetch_pc;
  logic [31:0] r_req_pc;
  logic        r_inflight;
  logic        r_seen;

  logic        w_deq;
  logic [CW:0] w_occ;
  logic        w_issue;
  logic        w_push;
  logic        w_full;
  logic        w_empty;
  fetch_pair_t w_wdata;
  fetch_pair_t w_head;

  assign w_deq = id_valid & id_ready;

  // Credit counts in-flight reads so a sync return always has a slot.
  assign w_occ = {1'b0, q_count}
               + (CW+1)'(r_inflight)
               - (CW+1)'(w_deq);

  assign w_issue = fetch_en & ~redirect_valid
                 & (w_occ < (CW+1)'(DEPTH));

  always_comb begin
    w_push       = 1'b0;
    w_wdata.inst = inst;
    w_wdata.pc   = r_fetch_pc;
    if (SYNC) begin
      w_push     = r_inflight & ~redirect_valid;
      w_wdata.pc = r_req_pc;
    end else begin
      w_push = w_issue;
    end
    w_push = w_push & (~w_full | w_deq);
  end

  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      r_fetch_pc <= RESET_PC;
      r_req_pc   <= '0;
      r_inflight <= 1'b0;
      r_seen     <= 1'b0;
    end else begin
      if (redirect_valid)
        r_fetch_pc <= word_align(redirect_pc);
      else if (w_issue)
        r_fetch_pc <= r_fetch_pc + 32'd4;
      if (w_issue)
        r_req_pc <= r_fetch_pc;
      r_inflight <= SYNC & w_issue;
      if (w_push)
        r_seen <= 1'b1;
    end
  end

  if_queue #(
    .WIDTH ($bits(fetch_pair_t)),
    .DEPTH (DEPTH)
  ) u_queue (
    .clk   (cpu_clk),
    .rst   (cpu_rst),
    .push  (w_push),
    .pop   (w_deq),
    .flush (redirect_valid),
    .wdata (w_wdata),
    .rdata (w_head),
    .full  (w_full),
    .empty (w_empty),
    .count (q_count)
  );

  assign inst_addr = r_fetch_pc[ADDR_W+1:2];
  assign id_valid  = ~w_empty;
  assign id_pc     = w_head.pc;
  assign id_inst   = w_head.inst;
  // pc4 reads zero until the first entry ever lands, matching reset.
  assign id_pc4    = r_seen ? (w_head.pc + 32'd4) : '0;

endmodule

// File: tb/tb_if_prefetch_unit.sv
// Bench: three fetch units (async/sync ROM, depth 4/2) vs a queue model.
module tb_if_prefetch_unit;

  localparam int DEP [3] = '{4, 4, 2};
  localparam bit SYN [3] = '{1'b0, 1'b1, 1'b0};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fen = 1'b0;
  logic        rv  = 1'b0;
  logic        rdy = 1'b0;
  logic [31:0] rpc = '0;

  logic [13:0] a   [3];
  logic        v   [3];
  logic [31:0] pc  [3];
  logic [31:0] pc4 [3];
  logic [31:0] ii  [3];
  logic [31:0] ins0, ins1, ins2;
  logic [2:0]  qc0, qc1;
  logic [1:0]  qc2;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] mq [3][0:7];
  int          mn [3];
  logic [31:0] mfp [3];
  bit          mpend [3];
  logic [31:0] mpp [3];

  always #5 clk = ~clk;

  function automatic logic [31:0] rom(input logic [13:0] x);
    return 32'h1000_0000 + {18'd0, x};
  endfunction

  function automatic logic [31:0] irom(input logic [31:0] p);
    return rom(p[15:2]);
  endfunction

  assign ins0 = rom(a[0]);
  assign ins2 = rom(a[2]);
  always @(posedge clk) ins1 <= rom(a[1]);

  if_prefetch_unit #(.ADDR_W(14), .DEPTH(4), .ROM_SYNC(0)) u0 (
    .cpu_clk(clk), .cpu_rst(rst), .fetch_en(fen),
    .inst_addr(a[0]), .inst(ins0),
    .redirect_valid(rv), .redirect_pc(rpc),
    .id_valid(v[0]), .id_ready(rdy), .id_pc(pc[0]),
    .id_pc4(pc4[0]), .id_inst(ii[0]), .q_count(qc0));

  if_prefetch_unit #(.ADDR_W(14), .DEPTH(4), .ROM_SYNC(1)) u1 (
    .cpu_clk(clk), .cpu_rst(rst), .fetch_en(fen),
    .inst_addr(a[1]), .inst(ins1),
    .redirect_valid(rv), .redirect_pc(rpc),
    .id_valid(v[1]), .id_ready(rdy), .id_pc(pc[1]),
    .id_pc4(pc4[1]), .id_inst(ii[1]), .q_count(qc1));

  if_prefetch_unit #(.ADDR_W(14), .DEPTH(2), .ROM_SYNC(0)) u2 (
    .cpu_clk(clk), .cpu_rst(rst), .fetch_en(fen),
    .inst_addr(a[2]), .inst(ins2),
    .redirect_valid(rv), .redirect_pc(rpc),
    .id_valid(v[2]), .id_ready(rdy), .id_pc(pc[2]),
    .id_pc4(pc4[2]), .id_inst(ii[2]), .q_count(qc2));

  function automatic logic [31:0] qcnt(input int k);
    if (k == 0) return {29'd0, qc0};
    if (k == 1) return {29'd0, qc1};
    return {30'd0, qc2};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      mn[k]    = 0;
      mpend[k] = 1'b0;
      mfp[k]   = 32'h0;
    end
  endtask

  task automatic model_step(input int k);
    if (mn[k] > 0 && rdy) begin
      for (int i = 0; i < 7; i++) mq[k][i] = mq[k][i+1];
      mn[k]--;
    end
    if (rv) begin
      mn[k]    = 0;
      mpend[k] = 1'b0;
      mfp[k]   = rpc & ~32'd3;
    end else begin
      if (SYN[k] && mpend[k]) begin
        mq[k][mn[k]] = mpp[k];
        mn[k]++;
        mpend[k] = 1'b0;
      end
      if (fen && (mn[k] + int'(mpend[k]) < DEP[k])) begin
        if (SYN[k]) begin
          mpend[k] = 1'b1;
          mpp[k]   = mfp[k];
        end else begin
          mq[k][mn[k]] = mfp[k];
          mn[k]++;
        end
        mfp[k] = mfp[k] + 32'd4;
      end
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("u%0d.valid", k), {31'd0, v[k]},
          (mn[k] > 0) ? 32'd1 : 32'd0);
      chk($sformatf("u%0d.q_count", k), qcnt(k), 32'(mn[k]));
      chk($sformatf("u%0d.inst_addr", k), {18'd0, a[k]},
          {18'd0, mfp[k][15:2]});
      if (mn[k] > 0) begin
        chk($sformatf("u%0d.id_pc", k), pc[k], mq[k][0]);
        chk($sformatf("u%0d.id_pc4", k), pc4[k], mq[k][0] + 32'd4);
        chk($sformatf("u%0d.id_inst", k), ii[k], irom(mq[k][0]));
      end
    end
  endtask

  task automatic cyc(input bit f, input bit r,
                     input logic [31:0] p, input bit d);
    fen = f;
    rv  = r;
    rpc = p;
    rdy = d;
    @(posedge clk);
    for (int k = 0; k < 3; k++) model_step(k);
    @(negedge clk);
    check_all();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst.u%0d.valid", k), {31'd0, v[k]}, 32'd0);
      chk($sformatf("rst.u%0d.q_count", k), qcnt(k), 32'd0);
      chk($sformatf("rst.u%0d.inst_addr", k), {18'd0, a[k]}, 32'd0);
      chk($sformatf("rst.u%0d.id_pc", k), pc[k], 32'd0);
      chk($sformatf("rst.u%0d.id_pc4", k), pc4[k], 32'd0);
      chk($sformatf("rst.u%0d.id_inst", k), ii[k], 32'd0);
    end
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_all();
  endtask

  initial begin
    bit          f, r, d;
    logic [31:0] p;

    @(negedge clk);
    do_reset();

    cyc(1, 0, 0, 1);
    chk("lat.u0.valid", {31'd0, v[0]}, 32'd1);
    chk("lat.u0.inst", ii[0], 32'h1000_0000);
    chk("lat.u1.valid", {31'd0, v[1]}, 32'd0);
    cyc(1, 0, 0, 1);
    chk("lat.u1.valid2", {31'd0, v[1]}, 32'd1);
    repeat (10) cyc(1, 0, 0, 1);

    do_reset();
    repeat (10) cyc(1, 0, 0, 0);
    chk("bp.u0.q_count", qcnt(0), 32'd4);
    chk("bp.u0.inst_addr", {18'd0, a[0]}, 32'd4);
    repeat (10) cyc(1, 0, 0, 1);

    do_reset();
    repeat (4) cyc(1, 0, 0, 0);
    chk("rd.u1.pre_count", qcnt(1), 32'd3);
    cyc(1, 1, 32'h0000_0203, 0);
    chk("rd.u1.q_count", qcnt(1), 32'd0);
    chk("rd.u1.inst_addr", {18'd0, a[1]}, 32'h80);
    cyc(1, 0, 0, 1);
    chk("rd.u1.bubble", {31'd0, v[1]}, 32'd0);
    cyc(1, 0, 0, 1);
    chk("rd.u1.valid", {31'd0, v[1]}, 32'd1);
    chk("rd.u1.id_pc", pc[1], 32'h200);

    repeat (3) cyc(1, 0, 0, 0);
    cyc(0, 1, 32'h0000_0040, 1);
    repeat (3) cyc(0, 0, 0, 1);
    chk("stall.u0.inst_addr", {18'd0, a[0]}, 32'h10);
    repeat (6) cyc(1, 0, 0, 1);

    cyc(1, 1, 32'hFFFF_FFFC, 1);
    cyc(1, 0, 0, 1);
    chk("wrap.u2.pc_a", pc[2], 32'hFFFF_FFFC);
    chk("wrap.u2.pc4_a", pc4[2], 32'h0);
    cyc(1, 0, 0, 1);
    chk("wrap.u2.pc_b", pc[2], 32'h0);
    chk("wrap.u2.pc4_b", pc4[2], 32'h4);

    repeat (5) cyc(1, 0, 0, 1);
    #2;
    do_reset();
    repeat (3) cyc(1, 0, 0, 1);

    repeat (400) begin
      f = ($urandom_range(0, 3) != 0);
      r = ($urandom_range(0, 15) == 0);
      d = ($urandom_range(0, 4) > 1);
      if ($urandom_range(0, 3) == 0)
        p = 32'hFFFF_FFF0 | ($urandom & 32'hF);
      else
        p = $urandom;
      cyc(f, r, p, d);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/if_prefetch_unit.md
Name: if_prefetch_unit

Overview:
Instruction-fetch front end for the pipelined successor of the single-cycle miniRV core. It owns the PC, drives the IROM word address and buffers fetched {pc, inst} pairs in a DEPTH-entry prefetch queue. The decode stage drains the queue through a valid/ready handshake. The execute stage redirects fetch on a taken branch or jump, which flushes the queue and any in-flight IROM reads. It supports both combinational (distributed) and synchronous (block) IROM.

Parameters:
- ADDR_W, 14: IROM word-address width; the byte PC is 32 bits and inst_addr = pc[ADDR_W+1:2].
- DEPTH, 4: prefetch queue entries; power of two, minimum 2.
- ROM_SYNC, 0: 0 = IROM data valid in the same cycle as the address; 1 = data valid one cycle later.
- RESET_PC, 32'h0000_0000: byte PC loaded on reset.

Ports:
- cpu_clk  input  1  clock.
- cpu_rst  input  1  asynchronous, active-high reset.
- fetch_en  input  1  0 stalls new IROM requests; queue contents and in-flight reads are kept.
- inst_addr  output  ADDR_W  IROM word address.
- inst  input  32  IROM read data.
- redirect_valid  input  1  taken branch/jump from execute.
- redirect_pc  input  32  redirect target byte address; bits [1:0] are ignored and treated as 0.
- id_valid  output  1  queue head valid.
- id_ready  input  1  decode accepts the head.
- id_pc  output  32  PC of the head instruction.
- id_pc4  output  32  id_pc + 4.
- id_inst  output  32  head instruction word.
- q_count  output  $clog2(DEPTH)+1  queue occupancy, for debug and performance counters.

Behaviour:
- Reset (asynchronous, any cycle, including mid-redirect):
  - fetch_pc = RESET_PC; queue empty; in-flight flag = 0; head/tail pointers = 0.
  - id_valid = 0, q_count = 0, id_pc = 0, id_pc4 = 0, id_inst = 0.
  - inst_addr = RESET_PC[ADDR_W+1:2].
- Dequeue: deq = id_valid & id_ready. The head advances at the clock edge. id_* outputs are registered queue-head contents and do not combinationally depend on id_ready.
- Issue condition: issue = fetch_en & ~redirect_valid & (q_count + inflight - deq < DEPTH).
  - On issue, fetch_pc <= fetch_pc + 4, wrapping modulo 2^32.
  - inst_addr always equals fetch_pc[ADDR_W+1:2], whether or not issue is asserted.
- ROM_SYNC=0: on issue, {fetch_pc, inst} is enqueued at the same edge.
- ROM_SYNC=1:
  - On issue, inflight <= 1 and req_pc <= fetch_pc.
  - In the next cycle, {req_pc, inst} is enqueued. The credit check above guarantees a free slot.
  - inflight clears unless another issue occurs in the same cycle; back-to-back issue sustains 1 instruction per cycle.
- Latency after reset release with fetch_en = 1:
  - ROM_SYNC=0: first id_valid in cycle 1.
  - ROM_SYNC=1: first id_valid in cycle 2.
  - Steady-state throughput is 1 instruction per cycle with id_ready held high.
- Redirect (highest priority):
  - At the edge, the queue is flushed (count = 0, pointers reset), inflight is cleared, and any IROM data returning in the following cycle is discarded.
  - fetch_pc <= {redirect_pc[31:2], 2'b00}.
  - No enqueue and no issue occur in the redirect cycle; a deq in the same cycle is still honoured (the head is consumed, then flushed).
  - Target fetch starts in the next cycle, giving a 1-cycle bubble (ROM_SYNC=0) or 2-cycle bubble (ROM_SYNC=1) before id_valid.
  - Consecutive redirects: only the last one takes effect.
- Full queue: with q_count = DEPTH and no deq, issue is suppressed and fetch_pc holds. Simultaneous deq and enqueue when full is legal and keeps q_count = DEPTH.
- Empty queue: id_valid = 0. id_pc and id_inst hold their previous values, and decode must ignore them.
- fetch_en = 0: in-flight data still lands and the queue keeps draining; only new issues stop.
- Address aliasing: a PC beyond the IROM range aliases modulo 2^(ADDR_W+2); no error is flagged.

Decomposition:
- defines.vh gains the following. All other values stay as module parameters.
  - `RESET_PC_DEFAULT.
  - `NOP_INST (32'h0000_0013), used by decode when inserting a bubble.
- One sub-module: if_queue, a generic synchronous FIFO.
  - Parameters WIDTH=64 and DEPTH.
  - Ports: push, pop, flush, full, empty, count.
  - Async reset; flush has priority over push.

Test Plan:
- Straight-line fetch, ROM_SYNC=0, id_ready=1, IROM word n = 0x1000_0000+n: id_valid from cycle 1, then id_pc = 0,4,8,… with id_inst = 0x1000_0000, 0x1000_0001, … one per cycle, no gaps.
- Backpressure, DEPTH=4: hold id_ready=0 for 10 cycles. Required: q_count saturates at 4; inst_addr freezes at 4 (PC 0x10); after id_ready=1, pcs 0x0…0x1C emerge in order with no loss or duplicates.
- Redirect in ROM_SYNC=1 with 3 entries queued and inflight=1, redirect_pc=0x0000_0203:
  - Next cycle: q_count = 0 and inst_addr = 0x80.
  - Stale returned data is dropped.
  - First id_pc = 0x200 after a 2-cycle bubble.
- Redirect and deq in the same cycle, plus redirect with fetch_en=0: the head is consumed once, no duplicate appears, and fetch_pc updates even while stalled.
- Asynchronous reset asserted mid-stream, between clock edges: all outputs clear immediately (id_valid=0, q_count=0, inst_addr=0) before the next edge; after release, fetch resumes from RESET_PC.
- PC wrap: redirect to 0xFFFF_FFFC with DEPTH=2. Required: id_pc sequence 0xFFFF_FFFC then 0x0000_0000, with id_pc4 = 0x0000_0000 and 0x0000_0004 respectively.
